// File: rtl/bit_stuffer_hs.sv
// Serial bit stuffer with valid/ready on both sides, frame-aware, configurable run length and polarity.
// Optional opening/closing flag generation is enabled by defining BITSTUFF_FLAG_EN.

module bit_stuffer_hs_chk #(
    parameter int STUFF_BIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_ready,
    input  logic out_valid,
    input  logic out_ready,
    input  logic out_data,
    input  logic out_last,
    input  logic out_stuffed,
    input  logic out_flag
);
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)
                                       && $stable(out_stuffed) && $stable(out_flag)));

    a_stuff_value: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && out_stuffed) |-> (out_data == 1'(STUFF_BIT)));

    a_ready_only_on_load: assert property (@(posedge clk) disable iff (!rst)
        in_ready |-> (!out_valid || out_ready));

    a_flag_not_stuffed: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && out_flag) |-> !out_stuffed);
endmodule

module bit_stuffer_hs #(
    parameter int RUN_LEN   = 5,
    parameter int STUFF_BIT = 0,
    parameter int CNT_W     = $clog2(RUN_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_last,
    output logic out_stuffed,
    output logic out_flag
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA       = 3'd1,
        STUFF      = 3'd2
`ifdef BITSTUFF_FLAG_EN
        ,
        OPEN_FLAG  = 3'd3,
        CLOSE_FLAG = 3'd4
`endif
    } state_t;

    localparam logic             STUFF_L = 1'(STUFF_BIT);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

`ifdef BITSTUFF_FLAG_EN
    localparam int                FLAG_LEN       = RUN_LEN + 3;
    localparam int                FLAG_W         = $clog2(FLAG_LEN);
    localparam logic [FLAG_W-1:0] FLAG_END       = FLAG_W'(FLAG_LEN - 1);
    localparam state_t            END_STATE      = CLOSE_FLAG;
    localparam logic              LAST_ON_DATA   = 1'b0;
    localparam logic              ACCEPT_IN_IDLE = 1'b0;

    // Flag is STUFF_BIT, RUN_LEN+1 copies of ~STUFF_BIT, STUFF_BIT.
    function automatic logic flag_bit(input logic [FLAG_W-1:0] idx);
        if (idx == {FLAG_W{1'b0}} || idx == FLAG_END) begin
            return STUFF_L;
        end else begin
            return ~STUFF_L;
        end
    endfunction
`else
    localparam state_t            END_STATE      = IDLE;
    localparam logic              LAST_ON_DATA   = 1'b1;
    localparam logic              ACCEPT_IN_IDLE = 1'b1;
`endif

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] run_r, run_nxt_s, run_upd_s;
    logic             last_pend_r, last_pend_nxt_s;
    logic             out_valid_r, valid_nxt_s;
    logic             out_data_r, data_nxt_s;
    logic             out_last_r, last_nxt_s;
    logic             out_stuffed_r, stuffed_nxt_s;
    logic             load_s, accept_s, hit_s, data_st_s, in_ready_s;
`ifdef BITSTUFF_FLAG_EN
    logic              out_flag_r, flag_nxt_s;
    logic [FLAG_W-1:0] flag_idx_r, flag_idx_nxt_s;
`endif

    assign load_s    = !out_valid_r || out_ready;
    assign run_upd_s = (in_data == ~STUFF_L) ? (run_r + CNT_W'(1)) : {CNT_W{1'b0}};
    assign hit_s     = (run_upd_s == RUN_MAX);
    assign accept_s  = in_valid && in_ready_s;

    // States in which an upstream bit may be taken.
    always_comb begin
        case (state_r)
            IDLE:    data_st_s = ACCEPT_IN_IDLE;
            DATA:    data_st_s = 1'b1;
            default: data_st_s = 1'b0;
        endcase
    end

    // Upstream ready follows the output register's load enable; held low in reset.
    always_comb begin
        if (rst && load_s && data_st_s) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Next-state and next-output computation; everything holds while the output stalls.
    always_comb begin
        state_nxt_s     = state_r;
        run_nxt_s       = run_r;
        last_pend_nxt_s = last_pend_r;
        valid_nxt_s     = out_valid_r;
        data_nxt_s      = out_data_r;
        last_nxt_s      = out_last_r;
        stuffed_nxt_s   = out_stuffed_r;
`ifdef BITSTUFF_FLAG_EN
        flag_nxt_s      = out_flag_r;
        flag_idx_nxt_s  = flag_idx_r;
`endif
        if (load_s) begin
            valid_nxt_s   = 1'b0;
            data_nxt_s    = 1'b0;
            last_nxt_s    = 1'b0;
            stuffed_nxt_s = 1'b0;
`ifdef BITSTUFF_FLAG_EN
            flag_nxt_s    = 1'b0;
`endif
            case (state_r)
                IDLE, DATA: begin
                    if (accept_s) begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = in_data;
                        if (hit_s) begin
                            // The frame's last bit may trigger a stuff; the stuff then closes it.
                            state_nxt_s     = STUFF;
                            run_nxt_s       = {CNT_W{1'b0}};
                            last_pend_nxt_s = in_last;
                        end else if (in_last) begin
                            state_nxt_s = END_STATE;
                            run_nxt_s   = {CNT_W{1'b0}};
                            last_nxt_s  = LAST_ON_DATA;
                        end else begin
                            state_nxt_s = DATA;
                            run_nxt_s   = run_upd_s;
                        end
`ifdef BITSTUFF_FLAG_EN
                    end else if (state_r == IDLE && in_valid) begin
                        state_nxt_s = OPEN_FLAG;
`endif
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                STUFF: begin
                    valid_nxt_s     = 1'b1;
                    data_nxt_s      = STUFF_L;
                    stuffed_nxt_s   = 1'b1;
                    last_nxt_s      = last_pend_r && LAST_ON_DATA;
                    last_pend_nxt_s = 1'b0;
                    if (last_pend_r) begin
                        state_nxt_s = END_STATE;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
`ifdef BITSTUFF_FLAG_EN
                OPEN_FLAG: begin
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = flag_bit(flag_idx_r);
                    flag_nxt_s  = 1'b1;
                    if (flag_idx_r == FLAG_END) begin
                        state_nxt_s    = DATA;
                        flag_idx_nxt_s = {FLAG_W{1'b0}};
                    end else begin
                        flag_idx_nxt_s = flag_idx_r + FLAG_W'(1);
                    end
                end
                CLOSE_FLAG: begin
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = flag_bit(flag_idx_r);
                    flag_nxt_s  = 1'b1;
                    last_nxt_s  = (flag_idx_r == FLAG_END);
                    if (flag_idx_r == FLAG_END) begin
                        state_nxt_s    = IDLE;
                        flag_idx_nxt_s = {FLAG_W{1'b0}};
                    end else begin
                        flag_idx_nxt_s = flag_idx_r + FLAG_W'(1);
                    end
                end
`endif
                default: begin
                    state_nxt_s     = IDLE;
                    run_nxt_s       = {CNT_W{1'b0}};
                    last_pend_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            run_r         <= {CNT_W{1'b0}};
            last_pend_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= 1'b0;
            out_last_r    <= 1'b0;
            out_stuffed_r <= 1'b0;
`ifdef BITSTUFF_FLAG_EN
            out_flag_r    <= 1'b0;
            flag_idx_r    <= {FLAG_W{1'b0}};
`endif
        end else begin
            state_r       <= state_nxt_s;
            run_r         <= run_nxt_s;
            last_pend_r   <= last_pend_nxt_s;
            out_valid_r   <= valid_nxt_s;
            out_data_r    <= data_nxt_s;
            out_last_r    <= last_nxt_s;
            out_stuffed_r <= stuffed_nxt_s;
`ifdef BITSTUFF_FLAG_EN
            out_flag_r    <= flag_nxt_s;
            flag_idx_r    <= flag_idx_nxt_s;
`endif
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;
    assign out_stuffed = out_stuffed_r;
`ifdef BITSTUFF_FLAG_EN
    assign out_flag    = out_flag_r;
`else
    assign out_flag    = 1'b0;
`endif

    bit_stuffer_hs_chk #(.STUFF_BIT(STUFF_BIT)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .in_ready    (in_ready_s),
        .out_valid   (out_valid_r),
        .out_ready   (out_ready),
        .out_data    (out_data_r),
        .out_last    (out_last_r),
        .out_stuffed (out_stuffed_r),
        .out_flag    (out_flag)
    );
endmodule
